// File: rtl/gate_bist_pkg.sv
// Shared types and next-state helpers for the gate BIST controller.
// The Galois step functions work on a wide container and are masked to the
// live width so one definition serves the pattern LFSR and the MISR alike.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } bist_state_e;

   // Widest register the helper functions can model.
   localparam int unsigned MAX_W = 64;

   localparam logic [15:0] DEF_LFSR_TAPS = 16'h002D;
   localparam logic [15:0] DEF_MISR_TAPS = 16'h1021;

   // Ones in the low w bits.
   function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
      logic [MAX_W-1:0] m;
      if (w >= MAX_W) begin
         m = '1;
      end else begin
         m = (MAX_W'(1) << w) - MAX_W'(1);
      end
      return m;
   endfunction

   // Galois shift-left step: shift in 0, fold taps when the MSB falls out.
   function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] v,
                                                  input logic [MAX_W-1:0] taps,
                                                  input int unsigned      w);
      logic [MAX_W-1:0] m;
      logic [MAX_W-1:0] r;
      m = width_mask(w);
      r = (v << 1) & m;
      if (v[w-1]) begin
         r = r ^ (taps & m);
      end
      return r;
   endfunction

   // Signature step: LFSR step with the response word folded in.
   function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] v,
                                                  input logic [MAX_W-1:0] taps,
                                                  input logic [MAX_W-1:0] d,
                                                  input int unsigned      w);
      return lfsr_next(v, taps, w) ^ (d & width_mask(w));
   endfunction

endpackage

// File: rtl/gate_bist_lfsr.sv
// Width/tap-parametrised Galois shift register. Without data it is a pattern
// generator; with USE_DATA set it compacts the data word each step (MISR).
module gate_bist_lfsr
   import gate_bist_pkg::*;
#(
   parameter int unsigned      WIDTH    = 16,
   parameter int unsigned      DATA_W   = 1,
   parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEF_LFSR_TAPS),
   parameter bit               USE_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              step,
   input  logic [DATA_W-1:0] data,
   output logic [WIDTH-1:0]  value
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic [MAX_W-1:0] nxt;
   logic             unused_nxt;

   // One Galois step of the current contents.
   always_comb begin
      if (USE_DATA) begin
         nxt = misr_next(MAX_W'(value_q), MAX_W'(TAPS), MAX_W'(data), WIDTH);
      end else begin
         nxt = lfsr_next(MAX_W'(value_q), MAX_W'(TAPS), WIDTH);
      end
   end

   // Bits above WIDTH are always masked to zero by the step functions.
   assign unused_nxt = ^nxt;

   // Load wins over step so a new run always starts from a clean value.
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (step) begin
         value_d = nxt[WIDTH-1:0];
      end
   end

   // Register contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/gate_bist_controller.sv
// BIST run/compare engine: streams LFSR patterns into a CUT, compacts the
// delayed responses into a MISR and compares the signature with a golden value.
module gate_bist_controller
   import gate_bist_pkg::*;
#(
   parameter int unsigned      IN_W      = 16,
   parameter int unsigned      OUT_W     = 10,
   parameter int unsigned      SIG_W     = 16,
   parameter int unsigned      PAT_CNT   = 1024,
   parameter int unsigned      RESP_LAT  = 1,
   parameter logic [IN_W-1:0]  LFSR_TAPS = IN_W'(DEF_LFSR_TAPS),
   parameter logic [SIG_W-1:0] MISR_TAPS = SIG_W'(DEF_MISR_TAPS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [IN_W-1:0]  seed_i,
   input  logic [SIG_W-1:0] golden_i,
   output logic [IN_W-1:0]  pat_o,
   output logic             pat_valid_o,
   input  logic [OUT_W-1:0] resp_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [SIG_W-1:0] sig_o
);

   localparam int unsigned CNT_W = (PAT_CNT > 1) ? $clog2(PAT_CNT) : 1;

   // Reject parameter sets the datapath cannot represent.
   if (IN_W < 2) begin : g_bad_in_w
      $error("IN_W must be at least 2");
   end
   if ((OUT_W > SIG_W) || (SIG_W > MAX_W) || (IN_W > MAX_W)) begin : g_bad_width
      $error("width parameters out of range");
   end
   if (PAT_CNT < 1) begin : g_bad_pat_cnt
      $error("PAT_CNT must be at least 1");
   end
   if ((RESP_LAT < 1) || (RESP_LAT > 4)) begin : g_bad_resp_lat
      $error("RESP_LAT must be 1..4");
   end

   bist_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          drn_q, drn_d;
   logic [RESP_LAT-1:0] vld_q, vld_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pvld_q, pvld_d;

   logic                start_ok;
   logic                abort_ok;
   logic                last_pat;
   logic                drain_end;
   logic                lfsr_step;
   logic                misr_step;
   logic [IN_W-1:0]     seed_fix;
   logic [IN_W-1:0]     pat;
   logic [SIG_W-1:0]    sig;

   assign start_ok  = (state_q == StIdle) && start;
   assign abort_ok  = abort && ((state_q == StRun) || (state_q == StDrain));
   assign last_pat  = (cnt_q == CNT_W'(PAT_CNT - 1));
   assign drain_end = (drn_q == 2'(RESP_LAT - 1));
   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   assign seed_fix  = (seed_i == '0) ? IN_W'(1) : seed_i;
   // The final RUN edge does not advance, so DRAIN shows the last pattern.
   assign lfsr_step = (state_q == StRun) && !abort_ok && !last_pat;
   // The oldest pipeline stage marks a response that is due this edge.
   assign misr_step = vld_q[RESP_LAT-1] && !abort_ok;

   // State, counters, capture pipeline and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         drn_q   <= '0;
         vld_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drn_q   <= drn_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pvld_q  <= pvld_d;
      end
   end

   // Next-state: the pattern counter ends RUN, the drain counter ends DRAIN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drn_d   = drn_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else if (last_pat) begin
               state_d = StDrain;
               drn_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDrain: begin
            if (abort) begin
               state_d = StIdle;
            end else if (drain_end) begin
               state_d = StDone;
            end else begin
               drn_d = drn_q + 1'b1;
            end
         end
         StDone: begin
            // A held start must drop before another run can be requested.
            if (!start) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   // Valid pipeline: stage i marks the pattern launched i edges ago.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = (state_d == StRun);
      for (int unsigned i = 1; i < RESP_LAT; i++) begin
         vld_d[i] = (state_d == StIdle) ? 1'b0 : vld_q[i-1];
      end
   end

   // Output decode from the next state so the flags are registered.
   always_comb begin
      pvld_d = (state_d == StRun);
      busy_d = (state_d == StRun) || (state_d == StDrain);
      done_d = (state_d == StDone);
   end

   gate_bist_lfsr #(
      .WIDTH    (IN_W),
      .DATA_W   (1),
      .TAPS     (LFSR_TAPS),
      .USE_DATA (1'b0)
   ) u_pattern (
      .clk      (clk),
      .rst      (rst),
      .load     (start_ok),
      .load_val (seed_fix),
      .step     (lfsr_step),
      .data     (1'b0),
      .value    (pat)
   );

   gate_bist_lfsr #(
      .WIDTH    (SIG_W),
      .DATA_W   (OUT_W),
      .TAPS     (MISR_TAPS),
      .USE_DATA (1'b1)
   ) u_misr (
      .clk      (clk),
      .rst      (rst),
      .load     (start_ok),
      .load_val ('0),
      .step     (misr_step),
      .data     (resp_i),
      .value    (sig)
   );

   assign pat_o       = pat;
   assign pat_valid_o = pvld_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign sig_o       = sig;
   // Compare against the live golden value; only meaningful in DONE.
   assign pass_o      = done_q && (sig == golden_i);

endmodule

// File: tb/tb_gate_bist_controller.sv
// Scoreboard bench: stimulus queues expected patterns and run results, a
// negedge monitor pops and compares whenever a DUT presents an output.
module tb_gate_bist_controller;

   typedef struct {
      logic [3:0] sig;
      logic       pass;
      int         edge_n;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic       abort;
   logic [3:0] seed;
   logic [3:0] golden;
   logic [3:0] pat_w  [3];
   logic       pvld_w [3];
   logic       busy_w [3];
   logic       done_w [3];
   logic       pass_w [3];
   logic [3:0] sig_w  [3];
   logic [3:0] d1, d2;

   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] pat_q [$];
   res_t       res_q [3][$];
   logic [2:0] done_prev = '0;

   logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                            4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Two-stage CUT model feeding the RESP_LAT=3 instance.
   always @(posedge clk) begin
      d1 <= pat_w[2];
      d2 <= d1;
   end

   // 16-pattern generator, responses tied low.
   gate_bist_controller #(
      .IN_W(4), .OUT_W(4), .SIG_W(4), .PAT_CNT(16), .RESP_LAT(1),
      .LFSR_TAPS(4'h3), .MISR_TAPS(4'h3)
   ) u_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort), .seed_i(seed),
      .golden_i(golden), .pat_o(pat_w[0]), .pat_valid_o(pvld_w[0]), .resp_i(4'h0),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]), .sig_o(sig_w[0])
   );

   // Direct loopback, RESP_LAT=1.
   gate_bist_controller #(
      .IN_W(4), .OUT_W(4), .SIG_W(4), .PAT_CNT(3), .RESP_LAT(1),
      .LFSR_TAPS(4'h3), .MISR_TAPS(4'h3)
   ) u_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort), .seed_i(seed),
      .golden_i(golden), .pat_o(pat_w[1]), .pat_valid_o(pvld_w[1]), .resp_i(pat_w[1]),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]), .sig_o(sig_w[1])
   );

   // Delayed loopback, RESP_LAT=3.
   gate_bist_controller #(
      .IN_W(4), .OUT_W(4), .SIG_W(4), .PAT_CNT(3), .RESP_LAT(3),
      .LFSR_TAPS(4'h3), .MISR_TAPS(4'h3)
   ) u_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort), .seed_i(seed),
      .golden_i(golden), .pat_o(pat_w[2]), .pat_valid_o(pvld_w[2]), .resp_i(d2),
      .busy_o(busy_w[2]), .done_o(done_w[2]), .pass_o(pass_w[2]), .sig_o(sig_w[2])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitor: pattern stream of u_a and done rising edge of every instance.
   always @(negedge clk) begin
      logic [3:0] e;
      res_t       r;
      if (pvld_w[0]) begin
         if (pat_q.size() == 0) begin
            fail("pat_extra");
         end else begin
            e = pat_q.pop_front();
            chk("pat", 32'(pat_w[0]), 32'(e));
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (done_w[i] && !done_prev[i]) begin
            if (res_q[i].size() == 0) begin
               $display("FAIL done_unexpected inst=%0d got done=1 expected 0", i);
               checks++;
               errors++;
            end else begin
               r = res_q[i].pop_front();
               chk($sformatf("sig%0d", i), 32'(sig_w[i]), 32'(r.sig));
               chk($sformatf("pass%0d", i), 32'(pass_w[i]), 32'(r.pass));
               chk($sformatf("done_edge%0d", i), cyc, r.edge_n);
            end
         end
         done_prev[i] <= done_w[i];
      end
   end

   // Request a run; lat = PAT_CNT + RESP_LAT gives the done edge after e0.
   task automatic launch(input int idx, input logic [3:0] s, input logic hold,
                         input bit expect_done, input int lat,
                         input logic [3:0] esig, input logic epass);
      res_t r;
      @(negedge clk);
      seed         = s;
      start_v[idx] = 1'b1;
      if (expect_done) begin
         r.sig    = esig;
         r.pass   = epass;
         r.edge_n = cyc + 1 + lat;
         res_q[idx].push_back(r);
      end
      @(negedge clk);
      if (!hold) start_v[idx] = 1'b0;
   endtask

   task automatic wait_result(input int idx, input int budget);
      int n = 0;
      while (res_q[idx].size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (res_q[idx].size() != 0) begin
         fail($sformatf("timeout_done%0d", idx));
         res_q[idx].delete();
      end
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      start_v = '0;
      abort   = 1'b0;
      seed    = 4'h0;
      golden  = 4'h0;
      repeat (2) @(negedge clk);
      chk("rst_pat", 32'(pat_w[0]), 0);
      chk("rst_pvld", 32'(pvld_w[0]), 0);
      chk("rst_busy", 32'(busy_w[0]), 0);
      chk("rst_done", 32'(done_w[0]), 0);
      chk("rst_sig", 32'(sig_w[0]), 0);
      chk("rst_pass", 32'(pass_w[0]), 0);
      rst = 1'b0;

      // Full LFSR period plus wrap; start held high through DONE.
      foreach (seq[i]) pat_q.push_back(seq[i]);
      launch(0, 4'h1, 1'b1, 1'b1, 17, 4'h0, 1'b1);
      wait_result(0, 40);
      repeat (3) @(negedge clk);
      chk("held_done", 32'(done_w[0]), 1);
      chk("held_busy", 32'(busy_w[0]), 0);
      chk("held_pvld", 32'(pvld_w[0]), 0);
      golden = 4'h1;
      #1 chk("pass_live_bad", 32'(pass_w[0]), 0);
      golden = 4'h0;
      #1 chk("pass_live_good", 32'(pass_w[0]), 1);
      start_v[0] = 1'b0;
      @(negedge clk);
      chk("release_done", 32'(done_w[0]), 0);
      @(negedge clk);
      chk("no_restart", 32'(busy_w[0]), 0);

      // Zero seed promoted to 1; golden mismatch.
      golden = 4'h1;
      foreach (seq[i]) pat_q.push_back(seq[i]);
      launch(0, 4'h0, 1'b0, 1'b1, 17, 4'h0, 1'b0);
      wait_result(0, 40);

      // Loopback signatures at both latencies.
      golden = 4'h4;
      launch(1, 4'h1, 1'b0, 1'b1, 4, 4'h4, 1'b1);
      wait_result(1, 20);
      launch(2, 4'h1, 1'b0, 1'b1, 6, 4'h4, 1'b1);
      wait_result(2, 20);

      // Abort on the second RUN cycle, then a clean rerun.
      launch(1, 4'h1, 1'b0, 1'b0, 0, 4'h0, 1'b0);
      chk("abort_first_pat", 32'(pat_w[1]), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 32'(busy_w[1]), 0);
      chk("abort_pvld", 32'(pvld_w[1]), 0);
      repeat (6) @(negedge clk);
      chk("abort_no_done", 32'(done_w[1]), 0);
      launch(1, 4'h1, 1'b0, 1'b1, 4, 4'h4, 1'b1);
      chk("rerun_first_pat", 32'(pat_w[1]), 1);
      wait_result(1, 20);

      // Asynchronous reset in the middle of DRAIN.
      launch(2, 4'h1, 1'b0, 1'b0, 0, 4'h0, 1'b0);
      n = 0;
      while (!(busy_w[2] && !pvld_w[2]) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) fail("timeout_drain");
      #2 rst = 1'b1;
      #1;
      chk("arst_pat", 32'(pat_w[2]), 0);
      chk("arst_pvld", 32'(pvld_w[2]), 0);
      chk("arst_busy", 32'(busy_w[2]), 0);
      chk("arst_done", 32'(done_w[2]), 0);
      chk("arst_sig", 32'(sig_w[2]), 0);
      chk("arst_pass", 32'(pass_w[2]), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("arst_no_done", 32'(done_w[2]), 0);

      chk("pat_q_left", pat_q.size(), 0);
      for (int i = 0; i < 3; i++) chk($sformatf("res_q_left%0d", i), res_q[i].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gate_bist_controller.md
# gate_bist_controller

Parametrised built-in self-test controller for combinational gate-library models in the simulator gate library. It drives an LFSR pseudo-random pattern stream into a circuit under test (CUT) of configurable input/output width. It compacts the CUT responses into a MISR signature and compares the signature against a golden value. It replaces hand-applied exhaustive stimulus for the fixed 16-in/10-out gate models with a generic, sequential run/compare engine.

## Interface
- `IN_W`, 16: CUT input width = LFSR width (≥ 2).
- `OUT_W`, 10: CUT output width (≤ `SIG_W`).
- `SIG_W`, 16: MISR / signature width.
- `PAT_CNT`, 1024: patterns per run (≥ 1).
- `RESP_LAT`, 1: edges between pattern launch and response capture (1..4).
- `LFSR_TAPS`, 16'h002D: Galois feedback mask, `IN_W` bits.
- `MISR_TAPS`, 16'h1021: Galois feedback mask, `SIG_W` bits.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  run request, sampled in IDLE only.
- `abort`  in  1  cancel run, sampled in RUN/DRAIN.
- `seed_i`  in  IN_W  LFSR seed, latched on accepted start.
- `golden_i`  in  SIG_W  expected signature, compared in DONE.
- `pat_o`  out  IN_W  pattern to CUT.
- `pat_valid_o`  out  1  pat_o is a live pattern.
- `resp_i`  in  OUT_W  CUT response.
- `busy_o`  out  1  high in RUN and DRAIN.
- `done_o`  out  1  high in DONE.
- `pass_o`  out  1  signature == golden_i, valid when done_o=1.
- `sig_o`  out  SIG_W  current MISR contents.

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE:
  - On start=1: latch seed_i (0 replaced by 1), clear MISR to 0, clear pattern counter, go to RUN.
- RUN:
  - pat_valid_o=1.
  - Each edge: LFSR ← {lfsr[IN_W-2:0],0} ^ (lfsr[IN_W-1] ? LFSR_TAPS : 0); counter+1.
  - After PAT_CNT patterns go to DRAIN.
  - The LFSR wraps naturally at its period; the counter, not the LFSR, ends the run.
- DRAIN:
  - pat_valid_o=0; pat_o holds the last pattern.
  - Stay RESP_LAT-1 edges (0 edges if RESP_LAT=1), then go to DONE.
- Capture:
  - The response to the pattern launched after edge k is folded into the MISR at edge k+RESP_LAT.
  - A RESP_LAT-deep valid shift register qualifies captures.
  - Exactly PAT_CNT captures happen per run.
- MISR update: sig ← {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? MISR_TAPS : 0) ^ zero-extended resp_i.
- DONE:
  - done_o=1; pass_o = (sig_o == golden_i), combinational against the live golden_i.
  - Go to IDLE when start=0; stay while start=1, so a held start never auto-restarts.
- abort=1 in RUN/DRAIN: go to IDLE next edge, done_o not asserted, sig_o keeps its partial value.
- start in RUN/DRAIN/DONE: ignored.
- abort in IDLE/DONE: ignored.

## Timing
- Reset values: state IDLE, pat_o=0, pat_valid_o=0, busy_o=0, done_o=0, pass_o=0, sig_o=0, counter 0, capture pipeline cleared.
- rst mid-run: immediate return to reset values; no done_o.
- start accepted at edge e0:
  - pat_o=seed from e0 to e0+1.
  - busy_o high from e0 to e0+PAT_CNT+RESP_LAT−1.
  - done_o high from edge e0+PAT_CNT+RESP_LAT.
- All outputs are registered except pass_o, which is compare logic on registered sig_o.

## Structure
- Package `gate_bist_pkg`: state enum (IDLE, RUN, DRAIN, DONE), default tap constants, LFSR/MISR next-state functions.
- One sub-module, `gate_bist_lfsr`, parametrised by width and taps. It is instantiated twice: as pattern generator (no data input) and as MISR (data input = response).

## Test plan
- IN_W=4, LFSR_TAPS=4'h3, seed 1, PAT_CNT=15 → pat_o 1,2,4,8,3,6,C,B,5,A,7,E,F,D,9; PAT_CNT=16 also checks wrap back to 1.
- resp_i tied 0, any PAT_CNT → sig_o=0; golden_i=0 → pass_o=1; golden_i=1 → pass_o=0.
- Loopback resp_i=pat_o (IN_W=OUT_W=SIG_W=4, both taps 4'h3), seed 1, PAT_CNT=3, RESP_LAT=1 → sig_o=4'h4, done_o rises at edge e0+4.
- Same loopback with RESP_LAT=3 and a 2-stage delayed CUT model → identical signature; done_o rises at e0+6.
- abort asserted on the 2nd RUN cycle → busy_o falls the next edge, done_o never asserts; a subsequent start runs cleanly from seed.
- rst pulsed mid-DRAIN → all outputs 0 asynchronously; start held high through DONE → no second run until start drops.
